// File: rtl/alu_pkg.sv
// Shared opcode map and FSM state encoding for the multicycle ALU.
package alu_pkg;

  localparam int unsigned OPW = 5;

  localparam logic [OPW-1:0] OP_ADD = 5'h00;
  localparam logic [OPW-1:0] OP_SUB = 5'h01;
  localparam logic [OPW-1:0] OP_MUL = 5'h02;
  localparam logic [OPW-1:0] OP_DIV = 5'h03;
  localparam logic [OPW-1:0] OP_MOD = 5'h04;
  localparam logic [OPW-1:0] OP_CMP = 5'h05;
  localparam logic [OPW-1:0] OP_AND = 5'h06;
  localparam logic [OPW-1:0] OP_OR  = 5'h07;
  localparam logic [OPW-1:0] OP_NOT = 5'h08;
  localparam logic [OPW-1:0] OP_SLL = 5'h09;
  localparam logic [OPW-1:0] OP_SRL = 5'h0A;
  localparam logic [OPW-1:0] OP_SRA = 5'h0B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative MUL / unsigned restoring DIV engine, one bit per step.
// Ports: start_i loads operands (op_mul_i selects MUL), step_i advances one
// iteration; done_c flags the final step, res_c (product or quotient) and
// rem_c are the post-step values, valid in the same cycle as done_c.
module alu_iter_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             step_i,
  input  logic             op_mul_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_c,
  output logic [WIDTH-1:0] res_c,
  output logic [WIDTH-1:0] rem_c
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             mul_q, mul_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH:0]   lhs, rhs;
  logic [WIDTH+1:0] add_c;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] acc_nx, sreg_nx;
  logic             cout;
  logic             unused_sum_msb;

  // Shared WIDTH+1 adder: MUL does acc*2 + bit*a, DIV does {rem,bit} - divisor.
  always_comb begin
    addend = sreg_q[WIDTH-1] ? opnd_q : '0;
    if (mul_q) begin
      lhs = {1'b0, acc_q[WIDTH-2:0], 1'b0};
      rhs = {1'b0, addend};
    end else begin
      lhs = {acc_q, sreg_q[WIDTH-1]};
      rhs = ~{1'b0, opnd_q};
    end
    add_c          = {1'b0, lhs} + {1'b0, rhs} + (WIDTH+2)'(!mul_q);
    cout           = add_c[WIDTH+1];
    unused_sum_msb = add_c[WIDTH];
    // Carry out of the subtract means the trial remainder is non-negative.
    if (mul_q)     acc_nx = add_c[WIDTH-1:0];
    else if (cout) acc_nx = add_c[WIDTH-1:0];
    else           acc_nx = lhs[WIDTH-1:0];
    sreg_nx = {sreg_q[WIDTH-2:0], (!mul_q) & cout};
  end

  assign done_c = step_i && (cnt_q == CW'(WIDTH-1));
  assign res_c  = mul_q ? acc_nx : sreg_nx;
  assign rem_c  = acc_nx;

  // Next-state: load on start, iterate on step.
  always_comb begin
    acc_d  = acc_q;
    sreg_d = sreg_q;
    opnd_d = opnd_q;
    mul_d  = mul_q;
    cnt_d  = cnt_q;
    if (start_i) begin
      acc_d  = '0;
      sreg_d = op_mul_i ? b_i : a_i;
      opnd_d = op_mul_i ? a_i : b_i;
      mul_d  = op_mul_i;
      cnt_d  = '0;
    end else if (step_i) begin
      acc_d  = acc_nx;
      sreg_d = sreg_nx;
      cnt_d  = done_c ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      sreg_q <= '0;
      opnd_q <= '0;
      mul_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      sreg_q <= sreg_d;
      opnd_q <= opnd_d;
      mul_q  <= mul_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle logic/shift/compare ops, iterative MUL/DIV/MOD.
// Ports: in_valid/in_ready accept opcode+operands (one op in flight),
// out_valid/out_ready return result and div_zero; flag_e/flag_gt hold the
// outcome of the most recent CMP.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_e,
  output logic             flag_gt,
  output logic             div_zero
);

  localparam int unsigned SHW = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             flag_e_q, flag_e_d;
  logic             flag_gt_q, flag_gt_d;
  logic             div_zero_q, div_zero_d;
  logic [4:0]       op_q, op_d;

  logic             eng_start, eng_step, eng_done_c;
  logic [WIDTH-1:0] eng_res_c, eng_rem_c;
  logic [WIDTH-1:0] alu_c;
  logic             big_shift;
  logic [SHW-1:0]   shamt;

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (eng_start),
    .step_i   (eng_step),
    .op_mul_i (alu_control == OP_MUL),
    .a_i      (a),
    .b_i      (b),
    .done_c   (eng_done_c),
    .res_c    (eng_res_c),
    .rem_c    (eng_rem_c)
  );

  // Single-cycle datapath; shift amounts beyond WIDTH-1 saturate.
  always_comb begin
    big_shift = (b > WIDTH'(WIDTH-1));
    shamt     = b[SHW-1:0];
    case (alu_control)
      OP_ADD:  alu_c = a + b;
      OP_SUB:  alu_c = a - b;
      OP_CMP:  alu_c = (a == b) ? '0 : ((a < b) ? '1 : WIDTH'(1));
      OP_AND:  alu_c = a & b;
      OP_OR:   alu_c = a | b;
      OP_NOT:  alu_c = ~a;
      OP_SLL:  alu_c = big_shift ? '0 : (a << shamt);
      OP_SRL:  alu_c = big_shift ? '0 : (a >> shamt);
      OP_SRA:  alu_c = big_shift ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> shamt);
      default: alu_c = '0;
    endcase
  end

  // Next-state and output-register update.
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    flag_e_d   = flag_e_q;
    flag_gt_d  = flag_gt_q;
    div_zero_d = div_zero_q;
    op_d       = op_q;
    eng_start  = 1'b0;
    eng_step   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d       = alu_control;
          div_zero_d = 1'b0;
          if (alu_control == OP_MUL) begin
            eng_start = 1'b1;
            state_d   = ST_BUSY;
          end else if ((alu_control == OP_DIV) || (alu_control == OP_MOD)) begin
            if (b == '0) begin
              result_d   = '0;
              div_zero_d = 1'b1;
              state_d    = ST_DONE;
            end else begin
              eng_start = 1'b1;
              state_d   = ST_BUSY;
            end
          end else begin
            result_d = alu_c;
            state_d  = ST_DONE;
            if (alu_control == OP_CMP) begin
              flag_e_d  = (a == b);
              flag_gt_d = (a > b);
            end
          end
        end
      end
      ST_BUSY: begin
        eng_step = 1'b1;
        if (eng_done_c) begin
          result_d = (op_q == OP_MOD) ? eng_rem_c : eng_res_c;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      flag_e_q    <= 1'b0;
      flag_gt_q   <= 1'b0;
      div_zero_q  <= 1'b0;
      op_q        <= '0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      flag_e_q    <= flag_e_d;
      flag_gt_q   <= flag_gt_d;
      div_zero_q  <= div_zero_d;
      op_q        <= op_d;
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign flag_e    = flag_e_q;
  assign flag_gt   = flag_gt_q;
  assign div_zero  = div_zero_q;

endmodule
